// File: rtl/trolley_system_button_servicer.sv
// trolley_system_button_servicer: Avalon-MM initiator that services an edge-capturing button PIO,
// debounces by clearing the capture after a holdoff, and reports presses as a pulse plus counters.
module trolley_system_button_servicer #(
  parameter int HOLDOFF_CYCLES = 50000,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               irq,
  input  logic [31:0]        readdata,
  output logic [1:0]         address,
  output logic               chipselect,
  output logic               write_n,
  output logic [31:0]        writedata,
  output logic               press_pulse,
  output logic [COUNT_W-1:0] press_count,
  output logic [7:0]         spurious_count,
  output logic               button_level,
  output logic               busy
);
  localparam logic [3:0] INIT_MASK    = 4'd0;
  localparam logic [3:0] IDLE         = 4'd1;
  localparam logic [3:0] RD_EDGE      = 4'd2;
  localparam logic [3:0] RD_EDGE_WAIT = 4'd3;
  localparam logic [3:0] CLR1         = 4'd4;
  localparam logic [3:0] RD_DATA      = 4'd5;
  localparam logic [3:0] RD_DATA_WAIT = 4'd6;
  localparam logic [3:0] HOLDOFF      = 4'd7;
  localparam logic [3:0] CLR2         = 4'd8;
  localparam int HW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  logic [3:0]    state, nxt;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic          rd, wr;
  logic [1:0]    next_addr;
  logic          unused_rd;

  assign unused_rd = ^readdata[31:1];
  assign busy = state != IDLE;

  // INIT_MASK spends one cycle loading its write onto the registered bus, then leaves
  always_comb begin
    nxt = state;
    case (state)
      INIT_MASK:    nxt = chipselect ? IDLE : INIT_MASK;
      IDLE:         nxt = enable && irq ? RD_EDGE : IDLE;
      RD_EDGE:      nxt = RD_EDGE_WAIT;
      RD_EDGE_WAIT: nxt = readdata[0] ? CLR1 : IDLE;
      CLR1:         nxt = RD_DATA;
      RD_DATA:      nxt = RD_DATA_WAIT;
      RD_DATA_WAIT: nxt = HOLDOFF;
      HOLDOFF:      nxt = hold_done ? CLR2 : HOLDOFF;
      CLR2:         nxt = IDLE;
      default:      nxt = INIT_MASK;
    endcase
  end

  // bus registers are loaded from the next state so they line up with the state they belong to
  assign rd = nxt == RD_EDGE || nxt == RD_DATA;
  assign wr = nxt == INIT_MASK || nxt == CLR1 || nxt == CLR2;
  assign next_addr = nxt == INIT_MASK ? 2'd2 : nxt == RD_DATA ? 2'd0 : (rd || wr) ? 2'd3 : 2'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= INIT_MASK;
      address        <= 2'd0;
      chipselect     <= 1'b0;
      write_n        <= 1'b1;
      writedata      <= 32'd0;
      press_pulse    <= 1'b0;
      press_count    <= '0;
      spurious_count <= 8'd0;
      button_level   <= 1'b0;
      hold_cnt       <= '0;
      hold_done      <= 1'b0;
    end else begin
      state       <= nxt;
      address     <= next_addr;
      chipselect  <= rd || wr;
      write_n     <= !wr;
      writedata   <= {31'd0, wr};
      press_pulse <= state == RD_DATA_WAIT;
      if (state == RD_DATA_WAIT) begin
        button_level <= readdata[0];
        press_count  <= press_count + COUNT_W'(1);
      end
      if (state == RD_EDGE_WAIT && !readdata[0] && spurious_count != 8'hff)
        spurious_count <= spurious_count + 8'd1;
      hold_cnt  <= state == HOLDOFF ? hold_cnt + HW'(1) : '0;
      hold_done <= state == HOLDOFF && hold_cnt == HOLD_LAST;
    end
  end
endmodule

// File: tb/tb_trolley_system_button_servicer.sv
// tb_trolley_system_button_servicer: responder model plus a latency-timeline reference model of the servicer.
module tb_trolley_system_button_servicer;
  localparam int H = 4;
  typedef logic [54:0] ov_t;
  typedef struct {
    int   n;
    logic en;
    logic btn;
    logic frc;
    int   pc;
    int   sc;
    logic lvl;
  } row_t;

  logic        clk = 1'b0, reset_n = 1'b1, enable = 1'b0, frc = 1'b0, button = 1'b1;
  logic        irq, chipselect, write_n, press_pulse, button_level, busy;
  logic [31:0] readdata, writedata;
  logic [1:0]  address;
  logic [7:0]  press_count, spurious_count;
  logic        mask, cap, bq;

  int   vecs = 0, errs = 0;
  int   k;
  logic [7:0] m_pc, m_sc;
  logic m_lvl;
  ov_t  exp_o;
  row_t rows[7];
  logic pat[16];

  trolley_system_button_servicer #(.HOLDOFF_CYCLES(H), .COUNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq), .readdata(readdata),
    .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .press_pulse(press_pulse), .press_count(press_count), .spurious_count(spurious_count),
    .button_level(button_level), .busy(busy)
  );

  always #5 clk = ~clk;

  // edge-capturing PIO responder: falling edges set the capture, writing 1 to addr 3 clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= 1'b0;
      cap <= 1'b0;
      bq <= 1'b1;
      readdata <= 32'd0;
    end else begin
      bq <= button;
      readdata <= (chipselect && write_n) ?
        {31'd0, address == 2'd3 ? cap : address == 2'd2 ? mask : address == 2'd0 ? bq : 1'b0} : 32'd0;
      if (chipselect && !write_n && address == 2'd2) mask <= writedata[0];
      cap <= (cap & ~(chipselect && !write_n && address == 2'd3 && writedata[0])) | (bq & ~button);
    end
  end
  assign irq = (cap & mask) | frc;

  // k is the cycle offset since service started (0 idle, -2/-1 the post-reset mask write)
  function automatic ov_t expect_for(input int nk);
    logic r, w;
    logic [1:0] a;
    r = nk == 1 || nk == 4;
    w = nk == -1 || nk == 3 || nk == 7 + H;
    a = nk == -1 ? 2'd2 : nk == 4 ? 2'd0 : (r || w) ? 2'd3 : 2'd0;
    return {a, r | w, ~w, {31'd0, w}, nk == 6, m_pc, m_sc, m_lvl, nk != 0};
  endfunction

  task automatic check_out(input string name);
    ov_t act;
    act = {address, chipselect, write_n, writedata, press_pulse, press_count, spurious_count, button_level, busy};
    vecs++;
    if (act !== exp_o) begin
      errs++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp_o);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    vecs++;
    if (got != want) begin
      errs++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  task automatic step(input logic en, input logic btn, input logic f, input string name);
    int nk;
    enable = en;
    button = btn;
    frc = f;
    #1;
    if (k == -2) nk = -1;
    else if (k == -1) nk = 0;
    else if (k == 0) nk = (en && irq) ? 1 : 0;
    else if (k == 2) begin
      nk = readdata[0] ? 3 : 0;
      if (!readdata[0] && m_sc != 8'hff) m_sc++;
    end else if (k == 5) begin
      nk = 6;
      m_lvl = readdata[0];
      m_pc++;
    end else nk = k == 7 + H ? 0 : k + 1;
    k = nk;
    exp_o = expect_for(nk);
    @(posedge clk);
    @(negedge clk);
    check_out(name);
  endtask

  task automatic do_reset(input string name);
    reset_n = 1'b0;
    button = 1'b1;
    frc = 1'b0;
    #1;
    k = -2;
    m_pc = 8'd0;
    m_sc = 8'd0;
    m_lvl = 1'b0;
    exp_o = expect_for(-2);
    check_out(name);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    rows = '{
      '{3,  1'b1, 1'b1, 1'b0, 0, 0, 1'b0},
      '{1,  1'b1, 1'b0, 1'b0, 0, 0, 1'b0},
      '{14, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0},
      '{1,  1'b1, 1'b1, 1'b1, 1, 0, 1'b0},
      '{4,  1'b1, 1'b1, 1'b0, 1, 1, 1'b0},
      '{20, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0},
      '{14, 1'b1, 1'b0, 1'b0, 2, 1, 1'b0}
    };
    pat = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    #2;
    do_reset("reset");
    foreach (rows[i]) begin
      for (int j = 0; j < rows[i].n; j++)
        step(rows[i].en, rows[i].btn, j == 0 && rows[i].frc, $sformatf("row%0d", i));
      check_val($sformatf("row%0d_press_count", i), press_count, rows[i].pc);
      check_val($sformatf("row%0d_spurious_count", i), spurious_count, rows[i].sc);
      check_val($sformatf("row%0d_button_level", i), button_level, rows[i].lvl);
    end
    // bounce: edges during holdoff must be discarded by the second clear
    step(1, 1, 0, "bounce_pre");
    step(1, 1, 0, "bounce_pre");
    foreach (pat[i]) step(1, pat[i], 0, "bounce");
    check_val("bounce_press_count", press_count, 3);
    check_val("bounce_capture", cap, 0);
    check_val("bounce_irq", irq, 0);
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 1, "spurious");
      step(1, 1, 0, "spurious");
      step(1, 1, 0, "spurious");
    end
    check_val("spurious_saturate", spurious_count, 255);
    check_val("spurious_press_count", press_count, 3);
    // asynchronous reset while in holdoff
    step(1, 1, 0, "hold_pre");
    step(1, 0, 0, "hold_pre");
    for (int i = 0; i < 20 && k != 7; i++) step(1, 0, 0, "to_hold");
    check_val("reached_holdoff", k, 7);
    #2;
    do_reset("reset_in_holdoff");
    for (int i = 0; i < 3; i++) step(1, 1, 0, "reinit");
    check_val("press_count_after_reset", press_count, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) != 0, ($urandom_range(0, 9) == 0) ? ~button : button,
           $urandom_range(0, 30) == 0, "random");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/trolley_system_button_servicer.md
Name: trolley_system_button_servicer

Overview:
Avalon-MM initiator that services a one-bit edge-capturing button PIO responder (data at addr 0, irq mask at addr 2, edge capture at addr 3). On irq it reads and clears the capture register, then samples the button level. After a fixed holdoff it clears the capture register again to discard switch bounce. It emits a one-cycle press event plus counters, so trolley control logic needs no CPU involvement.

Parameters:
HOLDOFF_CYCLES, 50000, cycles to wait after a reported press before discarding bounce captures (min 1).
COUNT_W, 16, width of press_count.

Ports:
clk  in  1  system clock, same clock as the responder
reset_n  in  1  asynchronous, active-low reset
enable  in  1  when high, servicing is allowed to start from IDLE
irq  in  1  responder interrupt (edge_capture & irq_mask)
readdata  in  32  responder read data; registered in the responder, so it is valid the cycle after the address is presented
address  out  2  responder address
chipselect  out  1  responder select
write_n  out  1  active-low write strobe
writedata  out  32  responder write data
press_pulse  out  1  one-cycle pulse per serviced press
press_count  out  COUNT_W  number of serviced presses; wraps
spurious_count  out  8  irq services whose capture read returned bit0=0; saturates at 255
button_level  out  1  last sampled data bit (addr 0)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: address=0, chipselect=0, write_n=1, writedata=0, press_pulse=0, press_count=0, spurious_count=0, button_level=0, busy=1 (state INIT_MASK).
- Bus outputs are registered per state. Reads: chipselect=1, write_n=1. Writes: chipselect=1, write_n=0, one cycle each. Idle bus: chipselect=0, write_n=1, address=0, writedata=0.
- The responder has no waitrequest. Each access completes in its cycle. Read data is captured from readdata in the cycle after the read cycle (the *_WAIT state).
- States and transitions:
  - INIT_MASK: write addr 2, writedata=1 -> IDLE. Occurs once after reset.
  - IDLE: if enable && irq -> RD_EDGE; else stay.
  - RD_EDGE: read addr 3 -> RD_EDGE_WAIT.
  - RD_EDGE_WAIT: if readdata[0]=1 -> CLR1. Otherwise spurious_count += 1 (saturating) -> IDLE.
  - CLR1: write addr 3, writedata=1 -> RD_DATA.
  - RD_DATA: read addr 0 -> RD_DATA_WAIT.
  - RD_DATA_WAIT: button_level <= readdata[0]; press_pulse=1 for exactly this cycle; press_count += 1 (wraps) -> HOLDOFF.
  - HOLDOFF: counter runs from 0 to HOLDOFF_CYCLES-1 and ignores irq -> CLR2.
  - CLR2: write addr 3, writedata=1 -> IDLE.
- Latency: irq high in IDLE (cycle 0) -> address 3 read in cycle 1 -> clear write in cycle 3 -> press_pulse in cycle 6.
- Minimum press-to-press period is 8+HOLDOFF_CYCLES cycles. Presses arriving during HOLDOFF are dropped by CLR2 by design.
- enable falling mid-sequence does not abort the sequence. It only blocks exit from IDLE. irq that stays high while enable=0 is serviced as soon as enable rises.
- irq is not latched. If irq drops before RD_EDGE, the capture read returns 0 and counts as spurious.
- Asynchronous reset at any time returns to INIT_MASK with all outputs at reset values. The mask is rewritten.

Test Plan:
- Reset release with the responder model attached -> one write addr 2 data 1 in the first cycle, then idle bus; busy falls in cycle 2.
- Single falling edge on the button (1->0) with HOLDOFF_CYCLES=4 -> read addr 3, write addr 3 data 1, read addr 0; press_pulse exactly 1 cycle at cycle 6 after irq; press_count=1; button_level=0; CLR2 write at cycle 11.
- Bounce: three falling edges within the holdoff -> press_count=1; edge_capture=0 after CLR2; irq low at return to IDLE.
- Forced irq pulse with edge_capture=0 at the read -> spurious_count=1, press_count unchanged, no clear write. Repeat 300 times -> spurious_count=255.
- enable=0 while irq=1 for 20 cycles -> no bus activity. enable=1 -> RD_EDGE next cycle.
- reset_n asserted during HOLDOFF -> outputs return to reset values immediately; after release, the INIT_MASK write occurs again and press_count=0.
